prod_div_recover: RTL and testbench

//  Receive-side decoder for the last-two-values product stream. Each incoming product
//  P = x[n]*x[n-1] is divided by the last recovered value to rebuild x[n].

---
 rtl/prod_div_recover.sv | 127 ++++++++++++
 tb/tb_prod_div_recover.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/prod_div_recover.sv
// Product-stream decoder: rebuilds x[n] = P / x[n-1] with a restoring serial divider.
// Optional build macro PROD_DIV_IGN_EN drops good results equal to IGN from the output.
module prod_div_recover #(
  parameter int W    = 4,
  parameter int SEED = 1,
  parameter int IGN  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [W-1:0]   seed_in,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [2*W-1:0] prod,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [W-1:0]   q,
  output logic           dz,
  output logic           ovf,
  output logic           inx
);
  localparam int            CW       = $clog2(2*W);
  localparam logic [CW-1:0] CNT_LAST = CW'(2*W-1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t         r_state, w_state_nx;
  logic [W-1:0]   r_prev, r_dvs, r_rem, r_q;
  logic [2*W-1:0] r_dvd;   // dividend bits shift out the top, quotient bits shift in below
  logic [CW-1:0]  r_cnt;
  logic           r_dz, r_ovf, r_inx, r_ign;

  logic [W:0]     w_rem_sh, w_rem_sub;
  logic           w_ge, w_last, w_ovf_nx, w_ign_nx;
  logic [W-1:0]   w_rem_nx;
  logic [2*W-1:0] w_quo;

  always_comb begin
    w_rem_sh  = {r_rem, r_dvd[2*W-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    w_rem_sub = w_rem_sh - {1'b0, r_dvs};
    // remainder always stays below the divisor, so W bits suffice
    w_rem_nx  = w_ge ? w_rem_sub[W-1:0] : w_rem_sh[W-1:0];
    w_quo     = {r_dvd[2*W-2:0], w_ge};
    w_last    = (r_cnt == CNT_LAST);
    w_ovf_nx  = |w_quo[2*W-1:W];
`ifdef PROD_DIV_IGN_EN
    w_ign_nx  = !w_ovf_nx && (w_quo[W-1:0] == W'(IGN));
`else
    w_ign_nx  = 1'b0;
`endif
  end

  always_comb begin
    w_state_nx = r_state;
    in_rdy     = (r_state == S_IDLE) && !ld;
    out_vld    = (r_state == S_DONE) && !r_ign;
    case (r_state)
      S_IDLE: if (!ld && in_vld) w_state_nx = (r_prev == '0) ? S_DONE : S_DIV;
      S_DIV:  if (w_last) w_state_nx = S_DONE;
      S_DONE: if (r_ign || out_rdy) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= W'(SEED);
      r_dvs  <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_dz   <= 1'b0;
      r_ovf  <= 1'b0;
      r_inx  <= 1'b0;
      r_ign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld) begin
            r_prev <= seed_in;
          end else if (in_vld) begin
            r_dvd <= prod;
            r_dvs <= r_prev;
            r_rem <= '0;
            r_cnt <= '0;
            if (r_prev == '0) begin
              r_q   <= '1;
              r_dz  <= 1'b1;
              r_ovf <= 1'b0;
              r_inx <= 1'b0;
              r_ign <= 1'b0;
            end
          end
        end
        S_DIV: begin
          r_dvd <= w_quo;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_dz  <= 1'b0;
            r_ovf <= w_ovf_nx;
            r_q   <= w_ovf_nx ? '1 : w_quo[W-1:0];
            r_inx <= !w_ovf_nx && (w_rem_nx != '0);
            r_ign <= w_ign_nx;
          end
        end
        S_DONE: begin
          // only a good quotient becomes the next divisor
          if ((r_ign || out_rdy) && !r_dz && !r_ovf) r_prev <= r_q;
        end
        default: ;
      endcase
    end
  end

  assign q   = r_q;
  assign dz  = r_dz;
  assign ovf = r_ovf;
  assign inx = r_inx;
endmodule

// File: tb/tb_prod_div_recover.sv
// Bench for prod_div_recover (W=4, SEED=5): directed cases then random products vs an arithmetic model.
module tb_prod_div_recover;
  localparam int W = 4, SEED = 5, IGN = 0;

  logic           clk = 1'b0, rst = 1'b1, ld = 1'b0, in_vld = 1'b0, out_rdy = 1'b1;
  logic [W-1:0]   seed_in = '0;
  logic [2*W-1:0] prod = '0;
  logic           in_rdy, out_vld, dz, ovf, inx;
  logic [W-1:0]   q;

  int tests = 0, fails = 0;
  int mprev = SEED;

  prod_div_recover #(.W(W), .SEED(SEED), .IGN(IGN)) dut (
    .clk(clk), .rst(rst), .ld(ld), .seed_in(seed_in), .in_vld(in_vld), .in_rdy(in_rdy),
    .prod(prod), .out_vld(out_vld), .out_rdy(out_rdy), .q(q), .dz(dz), .ovf(ovf), .inx(inx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int s);
    ld = 1'b1;
    seed_in = W'(s);
    #1;
    chk("in_rdy_during_ld", in_rdy, 0);
    step();
    ld = 1'b0;
    mprev = s;
  endtask

  // One product through the DUT; the model divides by the remembered sample with plain arithmetic.
  task automatic txn(input int p, input int stall);
    int e_q, e_dz, e_ovf, e_inx, pres, lat, n, quo;
    e_dz = 0; e_ovf = 0; e_inx = 0; pres = 1;
    if (mprev == 0) begin
      e_dz = 1; e_q = 15;
    end else begin
      quo = p / mprev;
      if (quo >= 16) begin
        e_ovf = 1; e_q = 15;
      end else begin
        e_q = quo;
        e_inx = (p % mprev) != 0;
      end
    end
`ifdef PROD_DIV_IGN_EN
    if (!e_dz && !e_ovf && e_q == IGN) pres = 0;
`endif
    n = 0;
    while (!in_rdy && n < 50) begin step(); n++; end
    chk("in_rdy_idle", in_rdy, 1);
    in_vld = 1'b1;
    prod = (2*W)'(p);
    out_rdy = (stall == 0);
    step();
    in_vld = 1'b0;
    lat = 0;
    while (!out_vld && lat < 2*W + 4) begin step(); lat++; end
    if (!pres) begin
      chk("ign_no_out_vld", out_vld, 0);
      chk("ign_back_idle", in_rdy, 1);
    end else begin
      chk("out_vld_seen", out_vld, 1);
      if (e_dz) chk("lat_dz", (lat <= 1), 1);
      else      chk("lat_div", lat, 2*W);
      chk("q", q, e_q);
      chk("dz", dz, e_dz);
      chk("ovf", ovf, e_ovf);
      chk("inx", inx, e_inx);
      for (int s = 0; s < stall; s++) begin
        step();
        chk("hold_vld", out_vld, 1);
        chk("hold_q", q, e_q);
        chk("hold_rdy", in_rdy, 0);
      end
      out_rdy = 1'b1;
      step();
      chk("vld_drop", out_vld, 0);
    end
    out_rdy = 1'b1;
    if (!e_dz && !e_ovf) mprev = e_q;
  endtask

  initial begin
    int p, a;
    step(); step();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_q", q, 0);
    chk("rst_flags", {dz, ovf, inx}, 0);
    chk("rst_in_rdy", in_rdy, 1);
    rst = 1'b0;

    txn(50, 0);            // q=10
    txn(50, 0);            // q=5
    txn(0, 0);             // q=0, prev=0
    txn(25, 0);            // divide by zero
    load(1);
    txn(200, 0);           // saturate, prev stays 1
    txn(7, 0);             // prev still 1 -> q=7
    load(3);
    txn(10, 3);            // inexact, stalled

    // reset in the middle of a division
    in_vld = 1'b1; prod = 8'd40;
    step();
    in_vld = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mprev = SEED;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_rdy", in_rdy, 1);
    txn(35, 0);            // prev back to 5 -> q=7

    load(5);
    txn(0, 0);             // q==IGN case
    txn(25, 0);            // dz presented in both builds

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0 || mprev == 0) load($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0 && mprev != 0) begin
        a = $urandom_range(0, 15);
        p = a * mprev + $urandom_range(0, mprev - 1);
      end else begin
        p = $urandom_range(0, 255);
      end
      txn(p, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
